uart_apb_sequencer: RTL



---
 rtl/uart_seq_pkg.sv | 39 +++
 rtl/uart_seq_rr_arb.sv | 58 +++++
 rtl/uart_apb_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_seq_pkg.sv
// uart_seq_pkg: shared constants for the CoreUARTapb sequencer.
//   - APB byte addresses of the UART registers
//   - STATUS register bit indices
//   - sequencer FSM state and APB phase enums
// The CFG_FRAC state only exists when UART_SEQ_FRAC_EN is defined.
package uart_seq_pkg;

  localparam logic [4:0] ADDR_TXDATA = 5'h00;
  localparam logic [4:0] ADDR_RXDATA = 5'h04;
  localparam logic [4:0] ADDR_CTRL1  = 5'h08;
  localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
  localparam logic [4:0] ADDR_STATUS = 5'h10;
  localparam logic [4:0] ADDR_FRAC   = 5'h14;

  localparam int ST_FRAMING_ERR = 4;
  localparam int ST_OVERFLOW    = 3;
  localparam int ST_PARITY_ERR  = 2;
  localparam int ST_RXRDY       = 1;
  localparam int ST_TXRDY       = 0;

  typedef enum logic [2:0] {
    S_CFG_LO,
    S_CFG_HI,
`ifdef UART_SEQ_FRAC_EN
    S_CFG_FRAC,
`endif
    S_POLL,
    S_RX_RD,
    S_TX_WR,
    S_GAP
  } seq_state_e;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_ACCESS
  } apb_phase_e;

endpackage

// File: rtl/uart_seq_rr_arb.sv
// uart_seq_rr_arb: round-robin pick among NREQ TX requesters.
//   PCLK, PRESET : clock, synchronous active-high reset (pointer -> 0)
//   req_valid    : requester holds a byte
//   adv, adv_idx : strobe after a grant is served; pointer becomes adv_idx+1 mod NREQ
//   gnt, gnt_idx : one-hot and binary index of the first valid requester at or
//                  after the pointer (gnt is all-zero when nothing is valid)
//   any_valid    : at least one requester is valid
module uart_seq_rr_arb #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [NREQ-1:0]  req_valid,
  input  logic             adv,
  input  logic [IDX_W-1:0] adv_idx,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any_valid
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               rr_j;

  // Walk the requesters starting at the pointer, wrapping at NREQ.
  always_comb begin
    gnt_idx = '0;
    gnt     = '0;
    found   = 1'b0;
    rr_j    = 0;
    for (int k = 0; k < NREQ; k++) begin
      rr_j = int'(ptr_q) + k;
      if (rr_j >= NREQ) rr_j = rr_j - NREQ;
      if (!found && req_valid[rr_j]) begin
        found   = 1'b1;
        gnt_idx = IDX_W'(rr_j);
      end
    end
    gnt[gnt_idx] = found;
  end

  assign any_valid = |req_valid;

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      if (int'(adv_idx) == NREQ - 1) ptr_d = '0;
      else                           ptr_d = adv_idx + 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: APB master owning a CoreUARTapb slave.
// After reset it writes CTRL1/CTRL2 (and FRAC when UART_SEQ_FRAC_EN is
// defined), then polls STATUS forever: RX bytes are drained first, otherwise
// one TX byte from a round-robin-selected requester is written per poll.
//   PCLK, PRESET          : clock, synchronous active-high reset
//   req_valid/req_data    : NREQ byte producers; req_ready pulses one-hot when served
//   rx_valid/rx_data/rx_err : received byte with {FE, OVF, PE} from the poll
//   init_done, apb_err    : configuration finished; sticky PSLVERR flag
//   PADDR..PSLVERR        : APB master port
// Macro: UART_SEQ_FRAC_EN adds the FRAC register write after CTRL2.
module uart_apb_sequencer
  import uart_seq_pkg::*;
#(
  parameter int          NREQ           = 4,
  parameter logic [12:0] BAUD_VALUE     = 13'd0,
  parameter logic        CFG_BIT8       = 1'b1,
  parameter logic        CFG_PARITY_EN  = 1'b0,
  parameter logic        CFG_ODD_N_EVEN = 1'b0,
  parameter logic [2:0]  BAUD_FRACTION  = 3'd0,
  parameter int          POLL_GAP       = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rx_valid,
  output logic [7:0]        rx_data,
  output logic [2:0]        rx_err,
  output logic              init_done,
  output logic              apb_err,
  output logic [4:0]        PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [7:0]        PWDATA,
  input  logic [7:0]        PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int         IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  seq_state_e       state_q, state_d;
  apb_phase_e       phase_q, phase_d;
  logic [7:0]       gap_q, gap_d;
  logic [IDX_W-1:0] gidx_q, gidx_d;
  logic [2:0]       stat_q, stat_d;
  logic [7:0]       pwdata_q, pwdata_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic             rx_valid_q, rx_valid_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic [2:0]       rx_err_q, rx_err_d;
  logic             init_done_q, init_done_d;
  logic             apb_err_q, apb_err_d;

  logic [4:0]       reg_addr;
  logic             reg_write;
  logic [7:0]       wr_data;
  logic             done;
  logic             adv;
  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_any;

  uart_seq_rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .req_valid (req_valid),
    .adv       (adv),
    .adv_idx   (gidx_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .any_valid (arb_any)
  );

  // Register target and write payload of the transfer owned by each state.
  always_comb begin
    reg_addr  = ADDR_STATUS;
    reg_write = 1'b0;
    wr_data   = 8'h00;
    case (state_q)
      S_CFG_LO: begin
        reg_addr  = ADDR_CTRL1;
        reg_write = 1'b1;
        wr_data   = BAUD_VALUE[7:0];
      end
      S_CFG_HI: begin
        reg_addr  = ADDR_CTRL2;
        reg_write = 1'b1;
        wr_data   = {BAUD_VALUE[12:8], CFG_ODD_N_EVEN, CFG_PARITY_EN, CFG_BIT8};
      end
`ifdef UART_SEQ_FRAC_EN
      S_CFG_FRAC: begin
        reg_addr  = ADDR_FRAC;
        reg_write = 1'b1;
        wr_data   = {5'b00000, BAUD_FRACTION};
      end
`endif
      S_RX_RD: reg_addr = ADDR_RXDATA;
      S_TX_WR: begin
        reg_addr  = ADDR_TXDATA;
        reg_write = 1'b1;
        wr_data   = req_data[int'(gidx_q)*8 +: 8];
      end
      default: ;
    endcase
  end

  assign PSEL    = (phase_q != PH_IDLE);
  assign PENABLE = (phase_q == PH_ACCESS);
  assign PADDR   = PSEL ? reg_addr : 5'h00;
  assign PWRITE  = PSEL & reg_write;
  assign PWDATA  = pwdata_q;
  assign done    = (phase_q == PH_ACCESS) && PREADY;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    gap_d       = gap_q;
    gidx_d      = gidx_q;
    stat_d      = stat_q;
    pwdata_d    = pwdata_q;
    req_ready_d = '0;
    rx_valid_d  = 1'b0;
    rx_data_d   = rx_data_q;
    rx_err_d    = rx_err_q;
    init_done_d = init_done_q;
    apb_err_d   = apb_err_q;
    adv         = 1'b0;

    if (state_q == S_GAP) begin
      // The gap replaces the idle cycle, so the poll goes straight to setup.
      if (gap_q == GAP_LAST) begin
        state_d = S_POLL;
        phase_d = PH_SETUP;
        gap_d   = 8'd0;
      end else begin
        gap_d = gap_q + 8'd1;
      end
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d  = PH_SETUP;
          // Latched here so a requester dropping valid cannot change the byte.
          pwdata_d = reg_write ? wr_data : pwdata_q;
        end
        PH_SETUP: phase_d = PH_ACCESS;
        PH_ACCESS: begin
          if (PREADY) begin
            phase_d   = PH_IDLE;
            apb_err_d = apb_err_q | PSLVERR;
            case (state_q)
              S_CFG_LO: state_d = S_CFG_HI;
`ifdef UART_SEQ_FRAC_EN
              S_CFG_HI: state_d = S_CFG_FRAC;
              S_CFG_FRAC: begin
                state_d     = S_POLL;
                init_done_d = 1'b1;
              end
`else
              S_CFG_HI: begin
                state_d     = S_POLL;
                init_done_d = 1'b1;
              end
`endif
              S_POLL: begin
                stat_d = {PRDATA[ST_FRAMING_ERR], PRDATA[ST_OVERFLOW], PRDATA[ST_PARITY_ERR]};
                if (PRDATA[ST_RXRDY]) begin
                  state_d = S_RX_RD;
                end else if (PRDATA[ST_TXRDY] && arb_any) begin
                  state_d = S_TX_WR;
                  gidx_d  = arb_idx;
                end else begin
                  state_d = S_GAP;
                  gap_d   = 8'd0;
                end
              end
              S_RX_RD: begin
                state_d    = S_POLL;
                rx_valid_d = 1'b1;
                rx_data_d  = PRDATA;
                rx_err_d   = stat_q;
              end
              S_TX_WR: begin
                state_d             = S_POLL;
                req_ready_d[gidx_q] = 1'b1;
                adv                 = 1'b1;
              end
              default: state_d = S_POLL;
            endcase
          end
        end
        default: phase_d = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= S_CFG_LO;
      phase_q     <= PH_IDLE;
      gap_q       <= 8'd0;
      gidx_q      <= '0;
      stat_q      <= 3'b000;
      pwdata_q    <= 8'h00;
      req_ready_q <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_err_q    <= 3'b000;
      init_done_q <= 1'b0;
      apb_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      gap_q       <= gap_d;
      gidx_q      <= gidx_d;
      stat_q      <= stat_d;
      pwdata_q    <= pwdata_d;
      req_ready_q <= req_ready_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      rx_err_q    <= rx_err_d;
      init_done_q <= init_done_d;
      apb_err_q   <= apb_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rx_valid  = rx_valid_q;
  assign rx_data   = rx_data_q;
  assign rx_err    = rx_err_q;
  assign init_done = init_done_q;
  assign apb_err   = apb_err_q;

endmodule
